// File: rtl/mem_seq_ctrl.sv
// Memory-port sequencer: runs fetch / load / store sequences with configurable read wait states.
// Optional completed-access counter is built when MEM_SEQ_ACCESS_CNT_EN is defined.
module mem_seq_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetch_req_i,
    input  logic        ldst_req_i,
    input  logic        is_store_i,
    output logic        load_addr_o,
    output logic        addr_sel_o,
    output logic [1:0]  mem_cmd_o,
    output logic        load_ir_o,
    output logic        load_pc_o,
    output logic        wb_load_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] access_cnt_o
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFRd   = 3'd1,
        StFLd   = 3'd2,
        StDAddr = 3'd3,
        StDRd   = 3'd4,
        StDWb   = 3'd5,
        StDWr   = 3'd6
    } state_e;

    localparam logic [1:0] CmdNone  = 2'b00;
    localparam logic [1:0] CmdRead  = 2'b01;
    localparam logic [1:0] CmdWrite = 2'b10;

    // Last value of the in-state wait counter before a read state exits.
    localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       store_q, store_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            store_q <= store_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        store_d = store_q;
        unique case (state_q)
            StIdle: begin
                wait_d = 4'd0;
                if (ldst_req_i) begin
                    state_d = StDAddr;
                    store_d = is_store_i;
                end else if (fetch_req_i) begin
                    state_d = StFRd;
                end
            end
            StFRd: begin
                if (wait_q == WaitLast) begin
                    state_d = StFLd;
                    wait_d  = 4'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StFLd: begin
                state_d = StIdle;
            end
            StDAddr: begin
                wait_d  = 4'd0;
                state_d = store_q ? StDWr : StDRd;
            end
            StDRd: begin
                if (wait_q == WaitLast) begin
                    state_d = StDWb;
                    wait_d  = 4'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StDWb: begin
                state_d = StIdle;
            end
            StDWr: begin
                state_d = StIdle;
            end
            default: begin
                // Unused encoding: recover to idle.
                state_d = StIdle;
                wait_d  = 4'd0;
            end
        endcase
    end

    // Moore output decode: outputs depend on state_q only.
    always_comb begin
        load_addr_o = 1'b0;
        addr_sel_o  = 1'b0;
        mem_cmd_o   = CmdNone;
        load_ir_o   = 1'b0;
        load_pc_o   = 1'b0;
        wb_load_o   = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_o = 1'b0;
            end
            StFRd: begin
                mem_cmd_o = CmdRead;
            end
            StFLd: begin
                mem_cmd_o = CmdRead;
                load_ir_o = 1'b1;
                load_pc_o = 1'b1;
                done_o    = 1'b1;
            end
            StDAddr: begin
                load_addr_o = 1'b1;
            end
            StDRd: begin
                mem_cmd_o  = CmdRead;
                addr_sel_o = 1'b1;
            end
            StDWb: begin
                mem_cmd_o  = CmdRead;
                addr_sel_o = 1'b1;
                wb_load_o  = 1'b1;
                done_o     = 1'b1;
            end
            StDWr: begin
                mem_cmd_o  = CmdWrite;
                addr_sel_o = 1'b1;
                done_o     = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

`ifdef MEM_SEQ_ACCESS_CNT_EN
    logic [15:0] access_cnt_q, access_cnt_d;

    always_comb begin
        access_cnt_d = access_cnt_q;
        if (done_o) begin
            access_cnt_d = access_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            access_cnt_q <= 16'h0000;
        end else begin
            access_cnt_q <= access_cnt_d;
        end
    end

    assign access_cnt_o = access_cnt_q;
`else
    assign access_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Bench for mem_seq_ctrl: directed vector table, reset/priority sequences, randomized run
// against a schedule-based model (expected per-cycle output vectors queued per accepted request).
module tb_mem_seq_ctrl;

    localparam int unsigned W = 1;

    // Output vector: {load_addr, addr_sel, mem_cmd[1:0], load_ir, load_pc, wb_load, busy, done}
    localparam logic [8:0] V_IDLE  = 9'b0_0_00_0_0_0_0_0;
    localparam logic [8:0] V_FRD   = 9'b0_0_01_0_0_0_1_0;
    localparam logic [8:0] V_FLD   = 9'b0_0_01_1_1_0_1_1;
    localparam logic [8:0] V_DADDR = 9'b1_0_00_0_0_0_1_0;
    localparam logic [8:0] V_DRD   = 9'b0_1_01_0_0_0_1_0;
    localparam logic [8:0] V_DWB   = 9'b0_1_01_0_0_1_1_1;
    localparam logic [8:0] V_DWR   = 9'b0_1_10_0_0_0_1_1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic        ldst_req = 1'b0;
    logic        is_store = 1'b0;
    logic        load_addr, addr_sel, load_ir, load_pc, wb_load, busy, done;
    logic [1:0]  mem_cmd;
    logic [15:0] access_cnt;
    logic [8:0]  out_vec;

    int total = 0;
    int bad = 0;

    logic [8:0]  model_q[$];
    logic [15:0] exp_cnt = 16'h0000;

    typedef struct {
        logic       f;
        logic       l;
        logic       s;
        logic [8:0] exp;
    } vec_t;
    vec_t tbl[22];

    always #5 clk = ~clk;

    assign out_vec = {load_addr, addr_sel, mem_cmd, load_ir, load_pc, wb_load, busy, done};

    mem_seq_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .fetch_req_i  (fetch_req),
        .ldst_req_i   (ldst_req),
        .is_store_i   (is_store),
        .load_addr_o  (load_addr),
        .addr_sel_o   (addr_sel),
        .mem_cmd_o    (mem_cmd),
        .load_ir_o    (load_ir),
        .load_pc_o    (load_pc),
        .wb_load_o    (wb_load),
        .busy_o       (busy),
        .done_o       (done),
        .access_cnt_o (access_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [8:0] model_exp();
        return (model_q.size() != 0) ? model_q[0] : V_IDLE;
    endfunction

    // One cycle: check at negedge, drive inputs, then advance the model at posedge.
    task automatic step(input logic f, input logic l, input logic s,
                        input logic [8:0] texp, input bit use_t);
        @(negedge clk);
        check("model_outputs", 32'(out_vec), 32'(model_exp()));
        check("access_cnt", 32'(access_cnt), 32'(exp_cnt));
        if (use_t) check("table_outputs", 32'(out_vec), 32'(texp));
        fetch_req = f;
        ldst_req  = l;
        is_store  = s;
        @(posedge clk);
        if (model_q.size() != 0) begin
`ifdef MEM_SEQ_ACCESS_CNT_EN
            if (model_q[0][0]) exp_cnt = exp_cnt + 16'd1;
`endif
            void'(model_q.pop_front());
        end else if (l) begin
            model_q.push_back(V_DADDR);
            if (s) begin
                model_q.push_back(V_DWR);
            end else begin
                for (int i = 0; i <= int'(W); i++) model_q.push_back(V_DRD);
                model_q.push_back(V_DWB);
            end
        end else if (f) begin
            for (int i = 0; i <= int'(W); i++) model_q.push_back(V_FRD);
            model_q.push_back(V_FLD);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        fetch_req = 1'b0;
        ldst_req = 1'b0;
        is_store = 1'b0;
        model_q.delete();
        exp_cnt = 16'h0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, V_IDLE};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, V_FRD};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, V_FRD};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, V_FLD};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, V_IDLE};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, V_DADDR};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, V_DRD};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, V_DRD};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, V_DWB};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, V_IDLE};
        tbl[10] = '{1'b0, 1'b0, 1'b0, V_DADDR};
        tbl[11] = '{1'b0, 1'b0, 1'b0, V_DWR};
        tbl[12] = '{1'b1, 1'b1, 1'b0, V_IDLE};
        tbl[13] = '{1'b1, 1'b0, 1'b0, V_DADDR};
        tbl[14] = '{1'b1, 1'b0, 1'b0, V_DRD};
        tbl[15] = '{1'b1, 1'b0, 1'b0, V_DRD};
        tbl[16] = '{1'b1, 1'b0, 1'b0, V_DWB};
        tbl[17] = '{1'b1, 1'b0, 1'b0, V_IDLE};
        tbl[18] = '{1'b0, 1'b1, 1'b1, V_FRD};
        tbl[19] = '{1'b1, 1'b0, 1'b0, V_FRD};
        tbl[20] = '{1'b0, 1'b0, 1'b0, V_FLD};
        tbl[21] = '{1'b0, 1'b0, 1'b0, V_IDLE};

        // Reset state
        #2;
        check("reset_outputs", 32'(out_vec), 32'(V_IDLE));
        check("reset_cnt", 32'(access_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table: fetch, load, store with is_store dropped, priority + held fetch,
        // requests pulsed while busy.
        foreach (tbl[i]) step(tbl[i].f, tbl[i].l, tbl[i].s, tbl[i].exp, 1'b1);

        // Reset in the middle of D_RD, between clock edges.
        step(1'b0, 1'b1, 1'b0, V_IDLE, 1'b1);
        step(1'b0, 1'b0, 1'b0, V_DADDR, 1'b1);
        step(1'b0, 1'b0, 1'b0, V_DRD, 1'b1);
        #2;
        reset = 1'b1;
        model_q.delete();
        exp_cnt = 16'h0000;
        #1;
        check("async_reset_outputs", 32'(out_vec), 32'(V_IDLE));
        @(negedge clk);
        check("reset_hold_outputs", 32'(out_vec), 32'(V_IDLE));
        check("reset_no_cnt", 32'(access_cnt), 32'h0);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, V_IDLE, 1'b1);
        step(1'b0, 1'b0, 1'b0, V_FRD, 1'b1);
        step(1'b0, 1'b0, 1'b0, V_FRD, 1'b1);
        step(1'b0, 1'b0, 1'b0, V_FLD, 1'b1);
        step(1'b0, 1'b0, 1'b0, V_IDLE, 1'b1);

        // Access counter: 5 fetches + 3 stores.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0, V_IDLE, 1'b0);
            for (int c = 0; c < int'(W) + 2; c++) step(1'b0, 1'b0, 1'b0, V_IDLE, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b1, V_IDLE, 1'b0);
            step(1'b0, 1'b0, 1'b0, V_IDLE, 1'b0);
            step(1'b0, 1'b0, 1'b0, V_IDLE, 1'b0);
        end
        @(negedge clk);
`ifdef MEM_SEQ_ACCESS_CNT_EN
        check("cnt_eight", 32'(access_cnt), 32'd8);
        dut.access_cnt_q = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        step(1'b0, 1'b1, 1'b1, V_IDLE, 1'b0);
        step(1'b0, 1'b0, 1'b0, V_DADDR, 1'b1);
        step(1'b0, 1'b0, 1'b0, V_DWR, 1'b1);
        @(negedge clk);
        check("cnt_wrap", 32'(access_cnt), 32'h0000);
`else
        check("cnt_tied_zero", 32'(access_cnt), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)), V_IDLE, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, V_IDLE, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_seq_ctrl.md
Name: mem_seq_ctrl

Overview:
- Sequencer for the CPU's memory port.
- Drives the data-address register load enable, the memory address mux select, the memory command, and the IR/PC/writeback strobes.
- Runs an instruction fetch, a data load (LDR) or a data store (STR) on request from the main control FSM, then returns a single-cycle done pulse.
- Inserts a configurable number of memory wait states.

Parameters:
WAIT_CYCLES, 1, extra read wait cycles before read data is valid (0..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
fetch_req  input  1  request instruction fetch; sampled only in IDLE
ldst_req  input  1  request data access; sampled only in IDLE
is_store  input  1  with ldst_req: 1=store, 0=load; latched in IDLE
load_addr  output  1  load enable for the 9-bit data-address register (captures datapath_out)
addr_sel  output  1  memory address mux: 0=PC, 1=data-address register
mem_cmd  output  2  2'b00 NONE, 2'b01 READ, 2'b10 WRITE
load_ir  output  1  capture read data into instruction register
load_pc  output  1  advance PC
wb_load  output  1  write read data into register file
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on the final cycle of any operation
access_cnt  output  16  completed-access count (feature-dependent, see below)

Behaviour:
- All outputs are Moore, decoded from state only. No combinational path from inputs to outputs.
- Reset (async, any state, including mid-operation):
  - state=IDLE, wait counter=0, latched store flag=0.
  - All outputs 0; mem_cmd=NONE.
  - An interrupted access is abandoned and no done pulse is issued.
- IDLE: all outputs 0.
  - ldst_req=1 -> D_ADDR; latch is_store. ldst_req takes priority over a simultaneous fetch_req.
  - Else fetch_req=1 -> F_RD.
  - Else stay in IDLE.
- F_RD: mem_cmd=READ, addr_sel=0.
  - Dwell 1+WAIT_CYCLES cycles (4-bit wait counter, cleared on entry), then -> F_LD.
- F_LD: mem_cmd=READ, addr_sel=0, load_ir=1, load_pc=1, done=1. Then -> IDLE.
- D_ADDR: load_addr=1 for one cycle; the datapath presents the address on datapath_out.
  - Latched store flag=1 -> D_WR; else -> D_RD.
- D_RD: mem_cmd=READ, addr_sel=1. Dwell 1+WAIT_CYCLES cycles, then -> D_WB.
- D_WB: mem_cmd=READ, addr_sel=1, wb_load=1, done=1. Then -> IDLE.
- D_WR: mem_cmd=WRITE, addr_sel=1, done=1, one cycle. Then -> IDLE.
- Latency, request-sample edge to the done cycle inclusive:
  - fetch: 2+WAIT_CYCLES cycles
  - load: 3+WAIT_CYCLES cycles
  - store: 2 cycles
- Requests arriving while busy=1 are ignored, not queued. A request held high through done is re-accepted on the first IDLE cycle after done.
- WAIT_CYCLES=0: each read state lasts exactly 1 cycle.
- mem_cmd is never WRITE with addr_sel=0.
- load_ir, load_pc and wb_load are mutually exclusive with each other and with load_addr.
- Illegal or unused state encodings -> IDLE on the next clock.

Optional Feature:
MEM_SEQ_ACCESS_CNT_EN
- Defined:
  - access_cnt is a 16-bit counter, reset to 0.
  - Increments by 1 on every cycle with done=1.
  - Wraps from 16'hFFFF to 16'h0000.
- Undefined:
  - No counter logic is built.
  - access_cnt is tied to 16'h0000.

Test Plan:
- Reset mid-D_RD (WAIT_CYCLES=1), reset asserted between clock edges -> outputs 0 immediately (asynchronous), busy=0, no done pulse; after release, fetch_req is accepted normally.
- WAIT_CYCLES=1, fetch_req pulse -> F_RD for 2 cycles (mem_cmd=01, addr_sel=0), then F_LD with load_ir=load_pc=done=1; done 3 cycles after the sample edge; busy low afterwards.
- WAIT_CYCLES=1, ldst_req=1 with is_store=0 -> load_addr for 1 cycle, mem_cmd=01 with addr_sel=1 for 2 cycles, then wb_load=done=1; total 4 cycles.
- ldst_req=1 with is_store=1, is_store dropped to 0 one cycle later -> load_addr, then mem_cmd=10 with addr_sel=1 and done=1 (latched flag used); total 2 cycles.
- fetch_req=1 and ldst_req=1 together in IDLE -> load/store sequence runs first; fetch_req held high starts F_RD on the first cycle after done; requests pulsed while busy produce nothing.
- MEM_SEQ_ACCESS_CNT_EN defined, WAIT_CYCLES=0:
  - 5 fetches + 3 stores -> access_cnt=8.
  - Force the counter to 16'hFFFF, run 1 access -> 16'h0000.
  - With the macro undefined -> access_cnt stays 0.
